// File: rtl/div_share_ctrl_if.sv
// Requester-side bundle for the shared divider controller.
// master = requester side, slave = controller side.
interface div_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTHN  = 32,
  parameter int WIDTHD  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*WIDTHN-1:0] req_numer;
  logic [NUM_REQ*WIDTHD-1:0] req_denom;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [WIDTHN-1:0]         resp_quotient;
  logic [WIDTHD-1:0]         resp_remain;
  logic                      resp_dbz;

  modport master (
    output req_valid,
    output req_numer,
    output req_denom,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_quotient,
    input  resp_remain,
    input  resp_dbz
  );

  modport slave (
    input  req_valid,
    input  req_numer,
    input  req_denom,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_quotient,
    output resp_remain,
    output resp_dbz
  );
endinterface

// File: rtl/div_share_ctrl.sv
// Round-robin share controller for one pipelined divider.
// Tags ride a shadow pipeline to route each result home.
module div_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int WIDTHN  = 32,
  parameter int WIDTHD  = 16,
  parameter int PIPE    = 4
) (
  input  logic              i_clock,
  input  logic              i_aclr,
  div_share_ctrl_if.slave   bus,
  output logic [WIDTHN-1:0] div_numer,
  output logic [WIDTHD-1:0] div_denom,
  output logic              div_clken,
  input  logic [WIDTHN-1:0] div_quotient,
  input  logic [WIDTHD-1:0] div_remain,
  output logic              busy
);

  localparam int IDW =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [IDW-1:0] id_t;

  typedef struct packed {
    logic              v;
    id_t               id;
    logic              dbz;
    logic [WIDTHD-1:0] lo;
  } tag_t;

  tag_t              tag_q [PIPE];
  tag_t              tag_d;
  tag_t              tail;
  id_t               last_q;
  id_t               gnt_id;
  id_t               cand;
  logic              gnt_any;
  logic              stall;
  logic              xfer;
  logic              dz;
  logic [WIDTHN-1:0] sel_numer;
  logic [WIDTHD-1:0] sel_denom;
  logic [PIPE-1:0]   vld;

  assign tail = tag_q[PIPE-1];

  // Stall holds the tail result until its owner takes it.
  assign stall =
    tail.v & ~bus.resp_ready[tail.id];

  // Reset forces the enable so the divider flushes.
  assign div_clken = i_aclr | ~stall;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = id_t'((int'(last_q) + k) % NUM_REQ);
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign sel_numer =
    bus.req_numer[int'(gnt_id)*WIDTHN +: WIDTHN];
  assign sel_denom =
    bus.req_denom[int'(gnt_id)*WIDTHD +: WIDTHD];
  assign dz = (sel_denom == '0);

  assign xfer = gnt_any & div_clken & ~i_aclr;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) bus.req_ready[gnt_id] = 1'b1;
  end

  // Zero divisors are swapped for one; the tag
  // carries the real answer around the divider.
  always_comb begin
    div_numer = '0;
    div_denom = '0;
    if (gnt_any) begin
      div_numer = sel_numer;
      div_denom = dz ? WIDTHD'(1) : sel_denom;
    end
  end

  always_comb begin
    tag_d     = '0;
    tag_d.v   = xfer;
    tag_d.id  = gnt_id;
    tag_d.dbz = dz;
    tag_d.lo  = sel_numer[WIDTHD-1:0];
  end

  always_ff @(posedge i_clock) begin
    if (i_aclr) begin
      last_q <= id_t'(NUM_REQ - 1);
      for (int i = 0; i < PIPE; i++)
        tag_q[i].v <= 1'b0;
    end else if (div_clken) begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < PIPE; i++)
        tag_q[i] <= tag_q[i-1];
      if (xfer) last_q <= gnt_id;
    end
  end

  always_comb begin
    bus.resp_valid = '0;
    if (tail.v && !i_aclr)
      bus.resp_valid[tail.id] = 1'b1;
  end

  always_comb begin
    bus.resp_quotient = div_quotient;
    bus.resp_remain   = div_remain;
    bus.resp_dbz      = tail.v & tail.dbz;
    if (tail.dbz) begin
      bus.resp_quotient = '1;
      bus.resp_remain   = tail.lo;
    end
  end

  always_comb begin
    vld = '0;
    for (int i = 0; i < PIPE; i++)
      vld[i] = tag_q[i].v;
  end

  assign busy = |vld;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: divider model, queue scoreboard
// and directed plus randomized scenarios.
module tb_div_share_ctrl;
  localparam int NR   = 4;
  localparam int WN   = 32;
  localparam int WD   = 16;
  localparam int PIPE = 4;

  typedef struct {
    logic [WN-1:0] q;
    logic [WD-1:0] r;
    logic          dbz;
  } res_t;

  typedef struct {
    int            id;
    logic [WN-1:0] q;
    logic [WD-1:0] r;
    logic          dbz;
    int            icyc;
    int            isc;
    bit            seen;
  } item_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WN-1:0] div_numer;
  logic [WD-1:0] div_denom;
  logic          div_clken;
  logic [WN-1:0] div_quotient;
  logic [WD-1:0] div_remain;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int sc     = 0;

  item_t exp_q[$];
  int    mlast;

  always #5 clk = ~clk;

  div_share_ctrl_if #(
    .NUM_REQ(NR), .WIDTHN(WN), .WIDTHD(WD)
  ) bus ();

  div_share_ctrl #(
    .NUM_REQ(NR), .WIDTHN(WN),
    .WIDTHD(WD), .PIPE(PIPE)
  ) dut (
    .i_clock      (clk),
    .i_aclr       (rst),
    .bus          (bus),
    .div_numer    (div_numer),
    .div_denom    (div_denom),
    .div_clken    (div_clken),
    .div_quotient (div_quotient),
    .div_remain   (div_remain),
    .busy         (busy)
  );

  // Behavioural fixed-latency divider with clock enable.
  logic [WN-1:0] mq [PIPE];
  logic [WD-1:0] mr [PIPE];

  always @(posedge clk) begin
    if (div_clken) begin
      if (div_denom == 0) begin
        mq[0] <= 32'hDEAD_BEEF;
        mr[0] <= 16'h0BAD;
      end else begin
        mq[0] <= div_numer / WN'(div_denom);
        mr[0] <= WD'(div_numer % WN'(div_denom));
      end
      for (int i = 1; i < PIPE; i++) begin
        mq[i] <= mq[i-1];
        mr[i] <= mr[i-1];
      end
    end
  end

  assign div_quotient = mq[PIPE-1];
  assign div_remain   = mr[PIPE-1];

  always @(posedge clk) cyc++;

  function automatic res_t ref_div(
    input logic [WN-1:0] n,
    input logic [WD-1:0] d
  );
    res_t r;
    if (d == 0) begin
      r.q   = '1;
      r.r   = n[WD-1:0];
      r.dbz = 1'b1;
    end else begin
      r.q   = n / WN'(d);
      r.r   = WD'(n % WN'(d));
      r.dbz = 1'b0;
    end
    return r;
  endfunction

  // Scoreboard: grant order, issue operands, response
  // order/data/latency, clock enable and busy.
  logic [NR-1:0] m_erdy;
  int            m_g;
  int            m_idx;
  item_t         m_it;
  res_t          m_res;
  logic [WN-1:0] m_n;
  logic [WD-1:0] m_d;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mlast = NR - 1;
    end else begin
      n_chk++;
      if (busy !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL busy cyc=%0d got=%b exp=%b",
                 cyc, busy, exp_q.size() != 0);
      end
      n_chk++;
      if (div_clken !==
          !(|(bus.resp_valid & ~bus.resp_ready))) begin
        n_fail++;
        $display("FAIL clken cyc=%0d got=%b", cyc,
                 div_clken);
      end
      if (bus.resp_valid !== '0) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL resp_spurious cyc=%0d got=%b exp=0",
                   cyc, bus.resp_valid);
        end else begin
          m_it = exp_q[0];
          if (bus.resp_valid !== (NR'(1) << m_it.id) ||
              bus.resp_quotient !== m_it.q ||
              bus.resp_remain !== m_it.r ||
              bus.resp_dbz !== m_it.dbz) begin
            n_fail++;
            $display({"FAIL resp_data cyc=%0d got v=%b q=%h r=%h",
                      " z=%b exp v=%b q=%h r=%h z=%b"},
                     cyc, bus.resp_valid, bus.resp_quotient,
                     bus.resp_remain, bus.resp_dbz,
                     NR'(1) << m_it.id, m_it.q, m_it.r,
                     m_it.dbz);
          end
          if (!m_it.seen) begin
            n_chk++;
            if (cyc - m_it.icyc != PIPE + sc - m_it.isc) begin
              n_fail++;
              $display("FAIL latency cyc=%0d got=%0d exp=%0d",
                       cyc, cyc - m_it.icyc,
                       PIPE + sc - m_it.isc);
            end
            exp_q[0].seen = 1'b1;
          end
          if (bus.resp_ready[m_it.id])
            void'(exp_q.pop_front());
        end
      end
      m_erdy = '0;
      m_g    = -1;
      if (div_clken) begin
        for (int k = 1; k <= NR; k++) begin
          m_idx = (mlast + k) % NR;
          if (m_g < 0 && bus.req_valid[m_idx]) m_g = m_idx;
        end
      end
      if (m_g >= 0) m_erdy[m_g] = 1'b1;
      n_chk++;
      if (bus.req_ready !== m_erdy) begin
        n_fail++;
        $display("FAIL arb cyc=%0d got=%b exp=%b", cyc,
                 bus.req_ready, m_erdy);
      end
      if (m_g >= 0) begin
        m_n = bus.req_numer[m_g*WN +: WN];
        m_d = bus.req_denom[m_g*WD +: WD];
        m_res = ref_div(m_n, m_d);
        exp_q.push_back('{m_g, m_res.q, m_res.r,
                          m_res.dbz, cyc, sc, 1'b0});
        mlast = m_g;
        n_chk++;
        if (div_numer !== m_n ||
            div_denom !== ((m_d == 0) ? WD'(1) : m_d)) begin
          n_fail++;
          $display("FAIL issue cyc=%0d got n=%h d=%h", cyc,
                   div_numer, div_denom);
        end
      end
      if (!div_clken) sc++;
    end
  end

  task automatic set_req(input int i,
                         input logic [WN-1:0] n,
                         input logic [WD-1:0] d);
    bus.req_numer[i*WN +: WN] = n;
    bus.req_denom[i*WD +: WD] = d;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req_valid  = '1;
    bus.resp_ready = '0;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== '0 || bus.resp_valid !== '0 ||
        div_clken !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_outs got rdy=%b rv=%b ce=%b exp 0 0 1",
               bus.req_ready, bus.resp_valid, div_clken);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || bus.resp_valid !== '0) begin
      n_fail++;
      $display("FAIL reset_after got busy=%b rv=%b exp 0 0",
               busy, bus.resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [NR-1:0] ev;
    set_req(2, 32'd100, 16'd7);
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_accept got=%b exp=0100",
               bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid[2] = 1'b0;
    for (int c = 1; c <= PIPE; c++) begin
      @(negedge clk);
      ev = (c == PIPE) ? 4'b0100 : 4'b0000;
      n_chk++;
      if (bus.resp_valid !== ev) begin
        n_fail++;
        $display("FAIL single_valid c=%0d got=%b exp=%b",
                 c, bus.resp_valid, ev);
      end
    end
    n_chk++;
    if (bus.resp_quotient !== 32'd14 ||
        bus.resp_remain !== 16'd2 || bus.resp_dbz !== 1'b0) begin
      n_fail++;
      $display("FAIL single_data got q=%0d r=%0d z=%b exp 14 2 0",
               bus.resp_quotient, bus.resp_remain, bus.resp_dbz);
    end
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle got busy=%b exp=0", busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    logic [WN-1:0] rn [NR];
    logic [WD-1:0] rd [NR];
    res_t          qe [16];
    int            g;
    logic [NR-1:0] ev;
    pulse_reset();
    for (int i = 0; i < NR; i++) begin
      rn[i] = $urandom;
      rd[i] = 16'($urandom_range(1, 65535));
      set_req(i, rn[i], rd[i]);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      g  = k % NR;
      ev = (k < 12) ? (NR'(1) << g) : '0;
      n_chk++;
      if (bus.req_ready !== ev) begin
        n_fail++;
        $display("FAIL rr_grant k=%0d got=%b exp=%b", k,
                 bus.req_ready, ev);
      end
      if (k < 12) qe[k] = ref_div(rn[g], rd[g]);
      if (k >= PIPE) begin
        n_chk++;
        if (bus.resp_valid !== (NR'(1) << ((k - PIPE) % NR)) ||
            bus.resp_quotient !== qe[k-PIPE].q ||
            bus.resp_remain !== qe[k-PIPE].r) begin
          n_fail++;
          $display("FAIL rr_resp k=%0d got v=%b q=%h r=%h exp q=%h r=%h",
                   k, bus.resp_valid, bus.resp_quotient,
                   bus.resp_remain, qe[k-PIPE].q, qe[k-PIPE].r);
        end
      end
      @(posedge clk); #1;
      if (k < 11) begin
        rn[g] = $urandom;
        rd[g] = 16'($urandom_range(1, 65535));
        set_req(g, rn[g], rd[g]);
      end else begin
        bus.req_valid = '0;
      end
    end
  endtask

  task automatic test_dbz();
    int t;
    set_req(1, 32'h1234_5678, 16'd0);
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 4'b0010 || div_denom !== 16'd1 ||
        div_numer !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL dbz_issue got rdy=%b d=%h n=%h exp 0010 1 12345678",
               bus.req_ready, div_denom, div_numer);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.resp_valid === '0 && t < 20);
    n_chk++;
    if (t != PIPE || bus.resp_valid !== 4'b0010) begin
      n_fail++;
      $display("FAIL dbz_timing got t=%0d v=%b exp t=%0d v=0010",
               t, bus.resp_valid, PIPE);
    end
    n_chk++;
    if (bus.resp_quotient !== 32'hFFFF_FFFF ||
        bus.resp_remain !== 16'h5678 || bus.resp_dbz !== 1'b1) begin
      n_fail++;
      $display("FAIL dbz_data got q=%h r=%h z=%b exp ffffffff 5678 1",
               bus.resp_quotient, bus.resp_remain, bus.resp_dbz);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [WN-1:0] n0, n3, n2;
    logic [WD-1:0] d0, d3, d2;
    res_t          e0, e3, e2;
    n0 = $urandom; d0 = 16'($urandom_range(1, 65535));
    n3 = $urandom; d3 = 16'($urandom_range(1, 300));
    n2 = $urandom; d2 = 16'($urandom_range(1, 65535));
    e0 = ref_div(n0, d0);
    e3 = ref_div(n3, d3);
    e2 = ref_div(n2, d2);
    bus.resp_ready = '1;
    set_req(0, n0, d0);
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_g0 got=%b exp=0001", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    set_req(3, n3, d3);
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL bp_g3 got=%b exp=1000", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    bus.resp_ready[0] = 1'b0;
    set_req(2, n2, d2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (div_clken !== 1'b0 || bus.req_ready !== '0 ||
          bus.resp_valid !== 4'b0001 ||
          bus.resp_quotient !== e0.q ||
          bus.resp_remain !== e0.r) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d got ce=%b rdy=%b v=%b q=%h exp q=%h",
                 c, div_clken, bus.req_ready, bus.resp_valid,
                 bus.resp_quotient, e0.q);
      end
      @(posedge clk); #1;
    end
    bus.resp_ready[0] = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.resp_valid !== 4'b0001 || div_clken !== 1'b1 ||
        bus.resp_quotient !== e0.q ||
        bus.req_ready !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_release got v=%b ce=%b q=%h rdy=%b exp q=%h",
               bus.resp_valid, div_clken, bus.resp_quotient,
               bus.req_ready, e0.q);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    n_chk++;
    if (bus.resp_valid !== 4'b1000 ||
        bus.resp_quotient !== e3.q || bus.resp_remain !== e3.r) begin
      n_fail++;
      $display("FAIL bp_second got v=%b q=%h r=%h exp 1000 %h %h",
               bus.resp_valid, bus.resp_quotient,
               bus.resp_remain, e3.q, e3.r);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.resp_valid !== 4'b0100 || bus.resp_quotient !== e2.q) begin
      n_fail++;
      $display("FAIL bp_third got v=%b q=%h exp 0100 %h",
               bus.resp_valid, bus.resp_quotient, e2.q);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midflight();
    res_t e;
    for (int i = 1; i <= 3; i++) begin
      set_req(i, $urandom, 16'($urandom_range(1, 65535)));
      @(posedge clk); #1;
      bus.req_valid = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b1 || bus.resp_valid !== '0 ||
        div_clken !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_in_reset got busy=%b v=%b ce=%b exp 1 0 1",
               busy, bus.resp_valid, div_clken);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NR; i++)
      set_req(i, 32'd1000 + 32'(i), 16'd3);
    e = ref_div(32'd1000, 16'd3);
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0 || bus.resp_valid !== '0 ||
        bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_restart got busy=%b v=%b rdy=%b exp 0 0 0001",
               busy, bus.resp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    for (int c = 1; c < PIPE; c++) begin
      @(negedge clk);
      n_chk++;
      if (bus.resp_valid !== '0) begin
        n_fail++;
        $display("FAIL mid_dropped c=%0d got=%b exp=0",
                 c, bus.resp_valid);
      end
    end
    @(negedge clk);
    n_chk++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_quotient !== e.q ||
        bus.resp_remain !== e.r) begin
      n_fail++;
      $display("FAIL mid_first got v=%b q=%0d r=%0d exp 0001 %0d %0d",
               bus.resp_valid, bus.resp_quotient, bus.resp_remain,
               e.q, e.r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_operands();
    set_req(3, 32'hFFFF_FFFF, 16'hFFFF);
    set_req(0, 32'd5, 16'd9);
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL max_g3 got=%b exp=1000", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.req_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL max_g0 got=%b exp=0001", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.resp_valid !== 4'b1000 ||
        bus.resp_quotient !== 32'h0001_0001 ||
        bus.resp_remain !== 16'h0) begin
      n_fail++;
      $display("FAIL max_big got v=%b q=%h r=%h exp 1000 00010001 0",
               bus.resp_valid, bus.resp_quotient, bus.resp_remain);
    end
    @(negedge clk);
    n_chk++;
    if (bus.resp_valid !== 4'b0001 || bus.resp_quotient !== 32'd0 ||
        bus.resp_remain !== 16'd5) begin
      n_fail++;
      $display("FAIL max_small got v=%b q=%h r=%h exp 0001 0 5",
               bus.resp_valid, bus.resp_quotient, bus.resp_remain);
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_ops(input int i);
    logic [WN-1:0] n;
    logic [WD-1:0] d;
    n = ($urandom_range(0, 7) == 0) ? '1 : WN'($urandom);
    case ($urandom_range(0, 7))
      0:       d = '0;
      1:       d = '1;
      2:       d = 16'($urandom_range(1, 15));
      default: d = 16'($urandom_range(1, 65535));
    endcase
    set_req(i, n, d);
  endtask

  task automatic test_random();
    logic [NR-1:0] acc;
    int            t;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          if ($urandom_range(0, 1) == 1) rand_ops(i);
          else bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i] &&
                     $urandom_range(0, 2) == 0) begin
          rand_ops(i);
        end
        bus.resp_ready[i] = ($urandom_range(0, 3) != 0);
      end
    end
    bus.req_valid  = '0;
    bus.resp_ready = '1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (busy !== 1'b0 && t < 40);
    n_chk++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_drain got busy=%b left=%0d exp 0 0",
               busy, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bus.req_valid  = '0;
    bus.req_numer  = '0;
    bus.req_denom  = '0;
    bus.resp_ready = '1;
    test_reset();
    test_single();
    test_round_robin();
    test_dbz();
    test_backpressure();
    test_reset_midflight();
    test_max_operands();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
